// File: rtl/input_debounce_sync_pkg.sv
// Shared types and default constants for the input debounce/synchroniser block.
// The optional DEBOUNCE_GLITCH_CNT_EN build uses GLITCH_W for its abort counter.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_CNT_W         = 8;
  localparam int GLITCH_W          = 8;

endpackage

// File: rtl/input_debounce_sync_sync_chain.sv
// Plain SYNC_STAGES-deep flop chain bringing an asynchronous level into the clk
// domain; no logic between stages so each flop gets a full cycle to resolve.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync
);

  logic [SYNC_STAGES-1:0] stage_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce_sync.sv
// Synchronises and debounces a raw level into a clean dout with rise/fall pulses.
// Define DEBOUNCE_GLITCH_CNT_EN to add a saturating glitch_cnt of aborted candidates.
module input_debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("input_debounce_sync: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 1 ||
        64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_stable
      $error("input_debounce_sync: STABLE_CYCLES must be 1..2**CNT_W-1");
    end
  endgenerate

  // Last qualifying count; reaching it while still differing commits the edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_d, rise_d, fall_d;
  logic             commit;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (din),
    .sync(sync)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync != dout) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = ST_QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_QUALIFY: begin
        if (sync == dout) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // A commit leaves dout equal to sync, so the next cycle starts settled.
    if (commit) begin
      dout_d  = ~dout;
      rise_d  = ~dout;
      fall_d  = dout;
      state_d = ST_STABLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= (state_d == ST_QUALIFY);
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;
  assign abort = (state_q == ST_QUALIFY) && (sync == dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  // Glitch statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// Bench for input_debounce_sync: a default instance and a STABLE_CYCLES=1 instance
// are driven in lock-step and compared against a run-length debounce model.
module tb_input_debounce_sync;
  import debounce_pkg::*;

  localparam int SS    = 2;
  localparam int STAB0 = 16;
  localparam int STAB1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din0 = 1'b0, din1 = 1'b0;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch0, glitch1;
`endif

  input_debounce_sync #(.SYNC_STAGES(SS), .STABLE_CYCLES(STAB0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din0),
    .dout(dout0), .rise(rise0), .fall(fall0), .busy(busy0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch0)
`endif
  );

  input_debounce_sync #(.SYNC_STAGES(SS), .STABLE_CYCLES(STAB1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .din(din1),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_vec;
  assign got_vec = {dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1};

  // Model: sync is din delayed SS edges; dout flips once the run of consecutive
  // samples disagreeing with it reaches the stable count.
  logic [1:0] hist[$];
  logic       m_dout[2];
  logic       m_rise[2];
  logic       m_fall[2];
  int         m_run[2];
  int         m_glitch[2];

  task automatic model_update(input logic r, input logic [1:0] d);
    logic [1:0] s;
    int lim;
    if (r) begin
      hist = {};
      for (int k = 0; k < SS; k++) hist.push_back(2'b00);
      for (int i = 0; i < 2; i++) begin
        m_dout[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        m_run[i] = 0; m_glitch[i] = 0;
      end
    end else begin
      s = hist.pop_front();
      hist.push_back(d);
      for (int i = 0; i < 2; i++) begin
        lim = (i == 0) ? STAB0 : STAB1;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (s[i] != m_dout[i]) begin
          m_run[i]++;
          if (m_run[i] >= lim) begin
            m_dout[i] = ~m_dout[i];
            m_rise[i] = m_dout[i];
            m_fall[i] = ~m_dout[i];
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i]++;
          m_run[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_dout[0], m_rise[0], m_fall[0], (m_run[0] > 0),
            m_dout[1], m_rise[1], m_fall[1], (m_run[1] > 0)};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic d0, input logic d1);
    @(negedge clk);
    rst = r; din0 = d0; din1 = d1;
    @(posedge clk);
    #1;
    model_update(r, {d1, d0});
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (got_vec !== 8'h00) begin
      failures++; $display("FAIL reset_values got=%b exp=%b", got_vec, 8'h00);
    end
    for (int e = 1; e <= 50; e++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (got_vec !== 8'h00) begin
        failures++; $display("FAIL steady_low edge=%0d got=%b exp=%b", e, got_vec, 8'h00);
      end
    end
  endtask

  task automatic test_clean_rise();
    int first_busy = -1, last_busy = -1, dout_edge = -1, rises = 0;
    int d1_edge = -1, busy1_seen = 0, fall_edge = -1, falls = 0;
    for (int e = 1; e <= 30; e++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL clean_rise edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
      if (busy0 && first_busy < 0) first_busy = e;
      if (busy0) last_busy = e;
      if (dout0 && dout_edge < 0) dout_edge = e;
      if (rise0) rises++;
      if (dout1 && d1_edge < 0) d1_edge = e;
      if (busy1) busy1_seen++;
    end
    checks++;
    if (first_busy != 3) begin failures++; $display("FAIL busy_first got=%0d exp=3", first_busy); end
    checks++;
    if (last_busy != 17) begin failures++; $display("FAIL busy_last got=%0d exp=17", last_busy); end
    checks++;
    if (dout_edge != 18) begin failures++; $display("FAIL rise_latency got=%0d exp=18", dout_edge); end
    checks++;
    if (rises != 1) begin failures++; $display("FAIL rise_count got=%0d exp=1", rises); end
    checks++;
    if (d1_edge != 3) begin failures++; $display("FAIL stable1_latency got=%0d exp=3", d1_edge); end
    checks++;
    if (busy1_seen != 0) begin failures++; $display("FAIL stable1_busy got=%0d exp=0", busy1_seen); end

    for (int e = 1; e <= 30; e++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL clean_fall edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
      if (fall0 && fall_edge < 0) fall_edge = e;
      if (fall0) falls++;
    end
    checks++;
    if (fall_edge != 18) begin failures++; $display("FAIL fall_latency got=%0d exp=18", fall_edge); end
    checks++;
    if (falls != 1) begin failures++; $display("FAIL fall_count got=%0d exp=1", falls); end
  endtask

  task automatic test_glitch();
    int rises = 0;
    for (int e = 1; e <= 35; e++) begin
      step(1'b0, (e <= 5), (e <= 5));
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL glitch edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
      if (rise0 || dout0) rises++;
    end
    checks++;
    if (rises != 0) begin failures++; $display("FAIL glitch_passed got=%0d exp=0", rises); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch0 !== 8'(m_glitch[0])) begin
      failures++; $display("FAIL glitch_cnt got=%0d exp=%0d", glitch0, m_glitch[0]);
    end
`endif
  endtask

  task automatic test_bounce();
    int rises = 0, rise_edge = -1;
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < 5; e++) begin
        step(1'b0, (e < 3), (e < 3));
        checks++;
        if (got_vec !== exp_vec()) begin
          failures++; $display("FAIL bounce p=%0d e=%0d got=%b exp=%b", p, e, got_vec, exp_vec());
        end
        if (rise0) rises++;
      end
    end
    for (int e = 1; e <= 30; e++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL bounce_settle edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
      if (rise0) begin rises++; if (rise_edge < 0) rise_edge = e; end
    end
    checks++;
    if (rises != 1 || rise_edge != 18) begin
      failures++; $display("FAIL bounce_rise got=%0d@%0d exp=1@18", rises, rise_edge);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch0 !== 8'(m_glitch[0])) begin
      failures++; $display("FAIL bounce_glitch_cnt got=%0d exp=%0d", glitch0, m_glitch[0]);
    end
`endif
    for (int e = 1; e <= 30; e++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (got_vec !== exp_vec()) begin
      failures++; $display("FAIL bounce_release got=%b exp=%b", got_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int dout_edge = -1;
    for (int e = 1; e <= 9; e++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (got_vec !== 8'h00) begin
      failures++; $display("FAIL reset_mid_clear got=%b exp=%b", got_vec, 8'h00);
    end
    for (int e = 1; e <= 25; e++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL reset_mid edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
      if (dout0 && dout_edge < 0) dout_edge = e;
    end
    checks++;
    if (dout_edge != 18) begin failures++; $display("FAIL reset_mid_latency got=%0d exp=18", dout_edge); end
    for (int e = 1; e <= 30; e++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic l0 = 1'b0, l1 = 1'b0;
    int len0 = 0, len1 = 0;
    for (int e = 1; e <= 1500; e++) begin
      if (len0 == 0) begin l0 = 1'($urandom_range(0, 1)); len0 = $urandom_range(1, 24); end
      if (len1 == 0) begin l1 = 1'($urandom_range(0, 1)); len1 = $urandom_range(1, 4); end
      len0--; len1--;
      step(1'b0, l0, l1);
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++; $display("FAIL random edge=%0d got=%b exp=%b", e, got_vec, exp_vec());
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch0 !== 8'(m_glitch[0]) || glitch1 !== 8'(m_glitch[1])) begin
      failures++; $display("FAIL random_glitch_cnt got=%0d/%0d exp=%0d/%0d",
                           glitch0, glitch1, m_glitch[0], m_glitch[1]);
    end
`endif
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic test_saturate();
    step(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 300; p++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (glitch0 !== 8'd255) begin
      failures++; $display("FAIL glitch_saturate got=%0d exp=255", glitch0);
    end
    checks++;
    if (got_vec !== exp_vec()) begin
      failures++; $display("FAIL saturate_outputs got=%b exp=%b", got_vec, exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_random();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debounce_sync.md
Name: input_debounce_sync

Overview:
Upstream input-conditioning stage for the clocked sample/hold stage that latches data input `a` on `posedge clk`. The block takes a raw asynchronous level `din`, synchronises it into the `clk` domain and debounces it. It drives a clean, glitch-free level `dout`, which connects directly to that stage's `a`. It also produces single-cycle rise/fall event pulses and a busy flag.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
STABLE_CYCLES, 16, consecutive differing synchronised samples required before `dout` changes; legal range >= 1.
CNT_W, 8, qualification counter width; elaboration error if STABLE_CYCLES > 2**CNT_W - 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
din  input  1  raw asynchronous level, e.g. switch or external pin.
dout  output  1  debounced, synchronised level; feeds downstream `a`.
rise  output  1  one-cycle pulse when `dout` goes 0->1.
fall  output  1  one-cycle pulse when `dout` goes 1->0.
busy  output  1  high while a candidate transition is qualifying.

Behaviour:
- Clock and reset: one clock domain, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values (sampled at clk edge with rst=1): sync chain all 0, dout=0, rise=0, fall=0, busy=0, counter=0, state=ST_STABLE. `rst` overrides every other input on that edge.
- Synchroniser: plain shift register of SYNC_STAGES flops. `sync` is the last stage. No logic between stages.
- FSM states: ST_STABLE, ST_QUALIFY. busy = (state==ST_QUALIFY), registered.
- ST_STABLE:
  - If sync==dout: hold, counter=0.
  - If sync!=dout and STABLE_CYCLES==1: commit immediately.
  - Else (sync!=dout): go to ST_QUALIFY, counter=1.
- ST_QUALIFY:
  - If sync==dout: abort. Go to ST_STABLE, counter=0, dout unchanged, no pulse.
  - Else if counter==STABLE_CYCLES-1: commit.
  - Else: counter+1.
- Commit: at the same edge, dout <= ~dout, rise/fall <= new value of dout / its inverse, state=ST_STABLE, counter=0.
- rise and fall are registered. Each is high for exactly one cycle and never both high together.
- Latency: dout changes at the (SYNC_STAGES+STABLE_CYCLES)-th rising edge, counting as edge 1 the edge that first samples din's new value. With defaults, that is edge 18.
- Counter never wraps. Its maximum value is STABLE_CYCLES-1.
- Simultaneous events: abort takes priority over counter increment. Commit and new-candidate cannot coincide, because after a commit dout==sync.
- Reset mid-qualification: discard the candidate. dout returns to 0 even if it was 1; no fall pulse is generated.
- din must be a level. Pulses shorter than STABLE_CYCLES clocks after synchronisation are filtered by design.

Optional Feature:
Macro: DEBOUNCE_GLITCH_CNT_EN
- Defined:
  - Adds output port `glitch_cnt`, 8 bits wide.
  - Increments by 1 on every abort (ST_QUALIFY -> ST_STABLE without commit).
  - Saturates at 255.
  - Reset value 0; cleared only by rst.
  - Commits do not count.
- Undefined: port and counter are absent. All other behaviour is identical cycle-for-cycle.

Decomposition:
- Package `debounce_pkg` contains:
  - state typedef (ST_STABLE, ST_QUALIFY);
  - default constants DEF_SYNC_STAGES=2, DEF_STABLE_CYCLES=16, GLITCH_W=8.
- Sub-module `sync_chain`: parameterised SYNC_STAGES flop shift register with sync reset. It is reused elsewhere for other async inputs.
- The FSM, counter and pulse logic stay in the top module.

Test Plan:
1. Reset then steady: rst for 2 cycles, din=0 for 50 cycles -> dout=0, rise=fall=busy=0 throughout.
2. Clean rise (defaults): din 0->1 and held -> busy high from edge 3 through edge 17; dout=1 at edge 18; rise=1 for that one cycle only. Then din 1->0 -> fall pulse 18 edges later.
3. Glitch rejection: din=1 for 5 cycles, then 0 -> dout stays 0, no rise. With DEBOUNCE_GLITCH_CNT_EN, glitch_cnt=1.
4. Bounce train: three 3-cycle high pulses separated by 2-cycle lows, then steady 1 -> single rise, 18 edges after the final 0->1. glitch_cnt=3 if enabled.
5. Reset mid-qualify: din=1, assert rst at edge 10 for 1 cycle, keep din=1 -> dout=0 and busy=0 after reset. Requalification completes; dout=1 at edge 18 after the reset-release edge, counting as edge 1 the first post-reset edge where din is sampled.
6. Boundary parameters: STABLE_CYCLES=1, SYNC_STAGES=2 -> dout follows din at edge 3 and busy never asserts. With the macro defined, 300 aborts -> glitch_cnt saturates at 255.
